// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with standard or first-word-fall-through read, almost flags and occupancy count.
// Define FIFO_SYNC_ERR_FLAGS_EN to add the sticky overflow/underflow outputs.
module fifo_sync_param #(
   parameter int AWIDTH        = 10,
   parameter int DWIDTH        = 32,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = 1020,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DWIDTH-1:0] din,
   input  logic              rd_en,
   output logic [DWIDTH-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [AWIDTH:0]   data_count
`ifdef FIFO_SYNC_ERR_FLAGS_EN
   ,
   output logic              overflow,
   output logic              underflow
`endif
);

   localparam int          DEPTH = 2 ** AWIDTH;
   localparam logic [31:0] AF_T  = AFULL_THRESH;
   localparam logic [31:0] AE_T  = AEMPTY_THRESH;

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AWIDTH:0]   wr_ptr;
   logic [AWIDTH:0]   rd_ptr;
   logic              ram_empty;
   logic              wr_acc;
   logic              ram_rd;
   logic              mid_valid;
   logic              out_valid;
   logic [31:0]       count_ext;

   assign ram_empty = (wr_ptr == rd_ptr);
   assign wr_acc    = wr_en & ~full;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
      end else if (wr_acc) begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   // NOTE: the storage array has no reset so it can map onto block or distributed RAM.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr[AWIDTH-1:0]] <= din;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // ram_q is the RAM's registered read port; dout is the presentation stage behind it.
         logic [DWIDTH-1:0] ram_q;
         logic              pop;
         logic              out_load;

         assign pop      = rd_en & out_valid;
         assign out_load = mid_valid & (~out_valid | pop);
         assign ram_rd   = ~ram_empty & (~mid_valid | out_load);
         assign empty    = ~out_valid;

         always_ff @(posedge clk) begin
            if (ram_rd) begin
               ram_q <= mem[rd_ptr[AWIDTH-1:0]];
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_ptr    <= '0;
               mid_valid <= 1'b0;
               out_valid <= 1'b0;
               dout      <= '0;
            end else begin
               if (ram_rd) begin
                  rd_ptr    <= rd_ptr + 1'b1;
                  mid_valid <= 1'b1;
               end else if (out_load) begin
                  mid_valid <= 1'b0;
               end
               if (out_load) begin
                  dout      <= ram_q;
                  out_valid <= 1'b1;
               end else if (pop) begin
                  out_valid <= 1'b0;
               end
            end
         end
      end else begin : g_std
         assign ram_rd    = rd_en & ~ram_empty;
         assign empty     = ram_empty;
         assign mid_valid = 1'b0;
         assign out_valid = 1'b0;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_ptr <= '0;
               dout   <= '0;
            end else if (ram_rd) begin
               rd_ptr <= rd_ptr + 1'b1;
               dout   <= mem[rd_ptr[AWIDTH-1:0]];
            end
         end
      end
   endgenerate

   // Words in flight to the output stage are still held, so they count toward occupancy.
   assign data_count   = (wr_ptr - rd_ptr) + {{AWIDTH{1'b0}}, mid_valid}
                                           + {{AWIDTH{1'b0}}, out_valid};
   assign full         = data_count[AWIDTH];
   assign count_ext    = 32'(data_count);
   assign almost_full  = (count_ext >= AF_T);
   assign almost_empty = (count_ext <= AE_T);

`ifdef FIFO_SYNC_ERR_FLAGS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en & full) begin
            overflow <= 1'b1;
         end
         if (rd_en & empty) begin
            underflow <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: a standard and a FWFT instance (16 deep) share stimulus and are
// compared against queue-based reference models.
module tb_fifo_sync_param;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] din = '0;

   logic [DW-1:0] s_dout, f_dout;
   logic          s_full, s_empty, s_af, s_ae;
   logic          f_full, f_empty, f_af, f_ae;
   logic [AW:0]   s_count, f_count;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
   logic          s_ovf, s_unf, f_ovf, f_unf;
   bit            m_s_ovf, m_s_unf, m_f_ovf, m_f_unf;
`endif

   always #5 clk = ~clk;

   fifo_sync_param #(.AWIDTH(AW), .DWIDTH(DW), .FWFT(0), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_std (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(s_dout),
      .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
      .data_count(s_count)
`ifdef FIFO_SYNC_ERR_FLAGS_EN
      , .overflow(s_ovf), .underflow(s_unf)
`endif
   );

   fifo_sync_param #(.AWIDTH(AW), .DWIDTH(DW), .FWFT(1), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(f_dout),
      .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
      .data_count(f_count)
`ifdef FIFO_SYNC_ERR_FLAGS_EN
      , .overflow(f_ovf), .underflow(f_unf)
`endif
   );

   int            total = 0;
   int            bad   = 0;
   // Reference models: held words; FWFT words carry the edge index at which they were written.
   logic [DW-1:0] sq[$];
   logic [DW-1:0] fq[$];
   int            ft[$];
   int            cyc = 0;
   logic [DW-1:0] m_s_dout = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // A FWFT word is presented once it is the head and at least two edges have passed since its write.
   function automatic bit f_vis();
      if (fq.size() == 0) return 1'b0;
      return cyc >= ft[0] + 2;
   endfunction

   task automatic check_state();
      check("s_count", 64'(s_count), 64'(sq.size()));
      check("s_empty", 64'(s_empty), 64'(sq.size() == 0));
      check("s_full",  64'(s_full),  64'(sq.size() == DEPTH));
      check("s_afull", 64'(s_af),    64'(sq.size() >= AF));
      check("s_aempty",64'(s_ae),    64'(sq.size() <= AE));
      check("s_dout",  64'(s_dout),  64'(m_s_dout));
      check("f_count", 64'(f_count), 64'(fq.size()));
      check("f_empty", 64'(f_empty), 64'(!f_vis()));
      check("f_full",  64'(f_full),  64'(fq.size() == DEPTH));
      check("f_afull", 64'(f_af),    64'(fq.size() >= AF));
      check("f_aempty",64'(f_ae),    64'(fq.size() <= AE));
      if (f_vis()) check("f_dout", 64'(f_dout), 64'(fq[0]));
`ifdef FIFO_SYNC_ERR_FLAGS_EN
      check("s_ovf", 64'(s_ovf), 64'(m_s_ovf));
      check("s_unf", 64'(s_unf), 64'(m_s_unf));
      check("f_ovf", 64'(f_ovf), 64'(m_f_ovf));
      check("f_unf", 64'(f_unf), 64'(m_f_unf));
`endif
   endtask

   // Called at a negedge; applies one cycle of stimulus and checks at the following negedge.
   task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
      bit s_wa, s_ra, f_wa, f_ra;
      wr_en = w;
      rd_en = r;
      din   = d;
      s_wa  = w && (sq.size() < DEPTH);
      s_ra  = r && (sq.size() > 0);
      f_wa  = w && (fq.size() < DEPTH);
      f_ra  = r && f_vis();
`ifdef FIFO_SYNC_ERR_FLAGS_EN
      if (w && sq.size() == DEPTH) m_s_ovf = 1'b1;
      if (r && sq.size() == 0)     m_s_unf = 1'b1;
      if (w && fq.size() == DEPTH) m_f_ovf = 1'b1;
      if (r && !f_vis())           m_f_unf = 1'b1;
`endif
      @(posedge clk);
      cyc++;
      if (s_ra) m_s_dout = sq.pop_front();
      if (s_wa) sq.push_back(d);
      if (f_ra) begin
         void'(fq.pop_front());
         void'(ft.pop_front());
      end
      if (f_wa) begin
         fq.push_back(d);
         ft.push_back(cyc);
      end
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
      check_state();
   endtask

   task automatic reset_check(input string tag);
      check({tag, "_s_empty"}, 64'(s_empty), 64'(1));
      check({tag, "_s_full"},  64'(s_full),  64'(0));
      check({tag, "_s_count"}, 64'(s_count), 64'(0));
      check({tag, "_s_dout"},  64'(s_dout),  64'(0));
      check({tag, "_s_flags"}, 64'({s_af, s_ae}), 64'(2'b01));
      check({tag, "_f_empty"}, 64'(f_empty), 64'(1));
      check({tag, "_f_full"},  64'(f_full),  64'(0));
      check({tag, "_f_count"}, 64'(f_count), 64'(0));
      check({tag, "_f_dout"},  64'(f_dout),  64'(0));
      check({tag, "_f_flags"}, 64'({f_af, f_ae}), 64'(2'b01));
`ifdef FIFO_SYNC_ERR_FLAGS_EN
      check({tag, "_err"}, 64'({s_ovf, s_unf, f_ovf, f_unf}), 64'(0));
`endif
   endtask

   // Asserts reset between clock edges, checks it takes effect at once, then releases at a negedge.
   task automatic do_reset(input string tag);
      #2 rst = 1'b1;
      #1 reset_check(tag);
      sq.delete();
      fq.delete();
      ft.delete();
      m_s_dout = '0;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
      m_s_ovf = 1'b0; m_s_unf = 1'b0; m_f_ovf = 1'b0; m_f_unf = 1'b0;
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset_check("por");
      rst = 1'b0;

      // Fill 0..15, one dropped write, drain in order, then read while empty.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i));
      check("fill_count", 64'(s_count), 64'(16));
      step(1'b1, 1'b0, 32'hDEAD_BEEF);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, '0);
         check("drain_order", 64'(s_dout), 64'(i));
      end
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b1, '0);

      // Pointer wrap: 40 words pushed through with interleaved reads.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(1000 + i));
      for (int i = 4; i < 40; i++) begin
         step(1'b1, 1'b0, DW'(1000 + i));
         step(1'b0, 1'b1, '0);
         if (i % 3 == 0) step(1'b1, 1'b1, DW'(5000 + i));
      end
      repeat (24) step(1'b0, 1'b1, '0);

      // Steady occupancy of 7 under simultaneous read/write, then read+write at full.
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, DW'(200 + i));
      repeat (2) step(1'b0, 1'b0, '0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DW'(300 + i));
      check("steady_count", 64'(s_count), 64'(7));
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, DW'(400 + i));
      step(1'b1, 1'b1, 32'hBAD0_BAD0);
      check("full_wr_rd_count", 64'(s_count), 64'(15));
      repeat (18) step(1'b0, 1'b1, '0);

      // FWFT presentation latency for a single word and its pop.
      step(1'b1, 1'b0, 32'hA5A5_A5A5);
      check("fwft_n0_empty", 64'(f_empty), 64'(1));
      check("std_n0_empty", 64'(s_empty), 64'(0));
      step(1'b0, 1'b0, '0);
      check("fwft_n1_empty", 64'(f_empty), 64'(1));
      step(1'b0, 1'b0, '0);
      check("fwft_n2_empty", 64'(f_empty), 64'(0));
      check("fwft_n2_dout", 64'(f_dout), 64'(32'hA5A5_A5A5));
      step(1'b0, 1'b1, '0);
      check("fwft_pop_count", 64'(f_count), 64'(0));
      check("fwft_pop_empty", 64'(f_empty), 64'(1));

      // Reset with five words held.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(700 + i));
      do_reset("mid");
      step(1'b0, 1'b1, '0);

      // Randomised traffic in fill, drain and balanced phases.
      for (int ph = 0; ph < 3; ph++) begin
         int wp, rp;
         wp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
         rp = 100 - wp;
         for (int i = 0; i < 150; i++)
            step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, $urandom);
      end

`ifdef FIFO_SYNC_ERR_FLAGS_EN
      do_reset("err_pre");
      for (int i = 0; i < 17; i++) step(1'b1, 1'b0, DW'(i));
      check("ovf_set", 64'({s_ovf, f_ovf}), 64'(2'b11));
      step(1'b0, 1'b0, '0);
      check("ovf_sticky", 64'({s_ovf, f_ovf}), 64'(2'b11));
      repeat (17) step(1'b0, 1'b1, '0);
      check("unf_set", 64'({s_unf, f_unf}), 64'(2'b11));
      do_reset("err_clr");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
